// File: rtl/receptor_medida_serial.sv
// receptor_medida_serial: 8N1 UART receiver that parses "CDU#" ASCII distance messages into 12-bit BCD
module receptor_medida_serial #(
  parameter int          DIVISOR    = 434,
  parameter logic [7:0]  TERMINADOR = 8'h23
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        RX,
  output logic [11:0] medida,
  output logic        medida_valida,
  output logic [7:0]  dado_recebido,
  output logic        pronto_rx,
  output logic        erro_quadro,
  output logic        erro_formato,
  output logic [3:0]  db_estado
);
  typedef enum logic [1:0] {OCIOSO, INICIO, DADOS, PARADA} rx_t;
  typedef enum logic [1:0] {ESPERA_C, ESPERA_D, ESPERA_U, ESPERA_T} ps_t;
  localparam logic [8:0] HALF = 9'(DIVISOR / 2 - 1);
  localparam logic [8:0] FULL = 9'(DIVISOR - 1);
  rx_t        rs, rs_n;
  ps_t        ps, ps_n;
  logic       rx_m, rx, tc, digito, ok, parada_tc;
  logic [8:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic [3:0] c, d, u;
  assign tc        = cnt == 9'd0;
  assign parada_tc = rs == PARADA && tc;
  assign digito    = dado_recebido >= 8'h30 && dado_recebido <= 8'h39;
  assign ok        = ps == ESPERA_T ? dado_recebido == TERMINADOR : digito;
  assign db_estado = {rs, ps};
  always_comb begin
    rs_n = rs == OCIOSO ? (rx ? OCIOSO : INICIO)
         : !tc          ? rs
         : rs == INICIO ? (rx ? OCIOSO : DADOS)
         : rs == DADOS  ? (idx == 3'd7 ? PARADA : DADOS)
         : OCIOSO;
    ps_n = erro_quadro || (pronto_rx && !ok) ? ESPERA_C
         : pronto_rx                         ? ps_t'(ps + 2'd1)
         : ps;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_m          <= 1'b1;
      rx            <= 1'b1;
      rs            <= OCIOSO;
      ps            <= ESPERA_C;
      cnt           <= '0;
      idx           <= '0;
      sh            <= '0;
      c             <= '0;
      d             <= '0;
      u             <= '0;
      medida        <= '0;
      dado_recebido <= '0;
      medida_valida <= 1'b0;
      pronto_rx     <= 1'b0;
      erro_quadro   <= 1'b0;
      erro_formato  <= 1'b0;
    end else begin
      rx_m          <= RX;
      rx            <= rx_m;
      rs            <= rs_n;
      ps            <= ps_n;
      cnt           <= rs == OCIOSO ? HALF : tc ? FULL : cnt - 9'd1;
      idx           <= rs != DADOS ? 3'd0 : tc ? idx + 3'd1 : idx;
      pronto_rx     <= parada_tc && rx;
      erro_quadro   <= parada_tc && !rx;
      erro_formato  <= pronto_rx && !ok;
      medida_valida <= pronto_rx && ok && ps == ESPERA_T;
      if (rs == DADOS && tc) sh <= {rx, sh[7:1]};
      if (parada_tc && rx) dado_recebido <= sh;
      if (pronto_rx && ok && ps == ESPERA_C) c <= dado_recebido[3:0];
      if (pronto_rx && ok && ps == ESPERA_D) d <= dado_recebido[3:0];
      if (pronto_rx && ok && ps == ESPERA_U) u <= dado_recebido[3:0];
      if (pronto_rx && ok && ps == ESPERA_T) medida <= {c, d, u};
    end
  end
endmodule

// File: tb/tb_receptor_medida_serial.sv
// tb_receptor_medida_serial: directed self-checking bench for the serial distance receiver
module tb_receptor_medida_serial;
  localparam int DIV = 260;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        RX = 1'b1;
  logic [11:0] medida;
  logic        medida_valida, pronto_rx, erro_quadro, erro_formato;
  logic [7:0]  dado_recebido;
  logic [3:0]  db_estado;
  int passed = 0, total = 0;
  int cyc = 0, n_pronto = 0, n_quadro = 0, n_formato = 0, n_valida = 0;
  int last_pronto = 0, lat = -1, both = 0, bad_change = 0;
  logic        rst_prev = 1'b1;
  logic [11:0] prev_medida = '0;
  logic [7:0]  rxq[$];
  receptor_medida_serial #(.DIVISOR(DIV), .TERMINADOR(8'h23)) dut (
    .clock(clock), .reset(reset), .RX(RX), .medida(medida), .medida_valida(medida_valida),
    .dado_recebido(dado_recebido), .pronto_rx(pronto_rx), .erro_quadro(erro_quadro),
    .erro_formato(erro_formato), .db_estado(db_estado)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    cyc++;
    if (pronto_rx) begin
      n_pronto++;
      last_pronto = cyc;
      rxq.push_back(dado_recebido);
    end
    if (erro_quadro) n_quadro++;
    if (erro_formato) n_formato++;
    if (medida_valida) begin
      n_valida++;
      lat = cyc - last_pronto;
    end
    if (erro_quadro && erro_formato) both++;
    if (!rst_prev && !reset && medida !== prev_medida && !medida_valida) bad_change++;
    prev_medida = medida;
    rst_prev = reset;
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(DIV);
    end
    RX = stop;
    tick(DIV);
    RX = 1'b1;
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    tick(3);
    reset = 1'b0;
    tick(5 * DIV);
    pulse_reset();
    tick(5 * DIV);
    total++; if (medida !== 12'h000) $display("FAIL reset_medida got %h want 000", medida); else passed++;
    total++; if (dado_recebido !== 8'h00) $display("FAIL reset_dado got %h want 00", dado_recebido); else passed++;
    total++; if (db_estado !== 4'h0) $display("FAIL reset_estado got %h want 0", db_estado); else passed++;
    total++; if (n_pronto + n_quadro + n_formato + n_valida !== 0) $display("FAIL reset_pulses got %0d want 0", n_pronto + n_quadro + n_formato + n_valida); else passed++;
  endtask
  task automatic test_good_message();
    int p0, v0;
    logic [7:0] exp_b[4];
    exp_b = '{8'h31, 8'h32, 8'h33, 8'h23};
    p0 = n_pronto;
    v0 = n_valida;
    rxq.delete();
    send_str("123#");
    tick(2 * DIV);
    total++; if (n_pronto - p0 !== 4) $display("FAIL good_pronto_count got %0d want 4", n_pronto - p0); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rxq.size() <= i) $display("FAIL good_byte%0d missing want %h", i, exp_b[i]);
      else if (rxq[i] !== exp_b[i]) $display("FAIL good_byte%0d got %h want %h", i, rxq[i], exp_b[i]);
      else passed++;
    end
    total++; if (medida !== 12'h123) $display("FAIL good_medida got %h want 123", medida); else passed++;
    total++; if (n_valida - v0 !== 1) $display("FAIL good_valid_count got %0d want 1", n_valida - v0); else passed++;
    total++; if (lat !== 1) $display("FAIL good_latency got %0d want 1", lat); else passed++;
  endtask
  task automatic test_framing_error();
    int p0, q0, f0, v0;
    send_byte("4", 1'b1);
    p0 = n_pronto;
    q0 = n_quadro;
    f0 = n_formato;
    send_byte("0", 1'b0);
    tick(DIV);
    total++; if (n_quadro - q0 !== 1) $display("FAIL frame_err_count got %0d want 1", n_quadro - q0); else passed++;
    total++; if (n_pronto - p0 !== 0) $display("FAIL frame_no_pronto got %0d want 0", n_pronto - p0); else passed++;
    total++; if (db_estado[1:0] !== 2'd0) $display("FAIL frame_parser_forced got %0d want 0", db_estado[1:0]); else passed++;
    v0 = n_valida;
    send_str("456#");
    tick(2 * DIV);
    total++; if (medida !== 12'h456) $display("FAIL frame_medida got %h want 456", medida); else passed++;
    total++; if (n_valida - v0 !== 1) $display("FAIL frame_valid_count got %0d want 1", n_valida - v0); else passed++;
    total++; if (n_formato - f0 !== 0) $display("FAIL frame_no_format got %0d want 0", n_formato - f0); else passed++;
  endtask
  task automatic test_format_error();
    int f0, v0;
    f0 = n_formato;
    v0 = n_valida;
    send_str("12#");
    tick(2 * DIV);
    total++; if (n_formato - f0 !== 1) $display("FAIL fmt_err_count got %0d want 1", n_formato - f0); else passed++;
    total++; if (medida !== 12'h456) $display("FAIL fmt_medida_hold got %h want 456", medida); else passed++;
    total++; if (n_valida - v0 !== 0) $display("FAIL fmt_no_valid got %0d want 0", n_valida - v0); else passed++;
    send_str("789#");
    tick(2 * DIV);
    total++; if (medida !== 12'h789) $display("FAIL fmt_medida got %h want 789", medida); else passed++;
    total++; if (n_valida - v0 !== 1) $display("FAIL fmt_valid_count got %0d want 1", n_valida - v0); else passed++;
  endtask
  task automatic test_term_in_c();
    int f0;
    f0 = n_formato;
    send_str("#");
    tick(2 * DIV);
    total++; if (n_formato - f0 !== 1) $display("FAIL term_c_err got %0d want 1", n_formato - f0); else passed++;
    total++; if (db_estado[1:0] !== 2'd0) $display("FAIL term_c_state got %0d want 0", db_estado[1:0]); else passed++;
  endtask
  task automatic test_digit_in_t();
    int f0, v0;
    f0 = n_formato;
    v0 = n_valida;
    send_str("1234");
    tick(2 * DIV);
    total++; if (n_formato - f0 !== 1) $display("FAIL digit_t_err got %0d want 1", n_formato - f0); else passed++;
    total++; if (n_valida - v0 !== 0) $display("FAIL digit_t_no_valid got %0d want 0", n_valida - v0); else passed++;
    total++; if (medida !== 12'h789) $display("FAIL digit_t_medida got %h want 789", medida); else passed++;
  endtask
  task automatic test_glitch();
    int p0, q0;
    p0 = n_pronto;
    q0 = n_quadro;
    RX = 1'b0;
    tick(50);
    total++; if (db_estado[3:2] !== 2'd1) $display("FAIL glitch_inicio got %0d want 1", db_estado[3:2]); else passed++;
    tick(40);
    RX = 1'b1;
    tick(2 * DIV);
    total++; if (db_estado[3:2] !== 2'd0) $display("FAIL glitch_ocioso got %0d want 0", db_estado[3:2]); else passed++;
    total++; if (n_pronto - p0 !== 0) $display("FAIL glitch_no_pronto got %0d want 0", n_pronto - p0); else passed++;
    total++; if (n_quadro - q0 !== 0) $display("FAIL glitch_no_frame_err got %0d want 0", n_quadro - q0); else passed++;
  endtask
  task automatic test_reset_mid_message();
    int f0, v0;
    send_str("98");
    pulse_reset();
    tick(2);
    total++; if (medida !== 12'h000) $display("FAIL rst_mid_medida0 got %h want 000", medida); else passed++;
    total++; if (db_estado !== 4'h0) $display("FAIL rst_mid_state got %h want 0", db_estado); else passed++;
    f0 = n_formato;
    v0 = n_valida;
    send_str("7#");
    tick(2 * DIV);
    total++; if (n_formato - f0 !== 1) $display("FAIL rst_mid_fmt_err got %0d want 1", n_formato - f0); else passed++;
    total++; if (n_valida - v0 !== 0) $display("FAIL rst_mid_no_valid got %0d want 0", n_valida - v0); else passed++;
    total++; if (medida !== 12'h000) $display("FAIL rst_mid_medida got %h want 000", medida); else passed++;
  endtask
  initial begin
    test_reset();
    test_good_message();
    test_framing_error();
    test_format_error();
    test_term_in_c();
    test_digit_in_t();
    test_glitch();
    test_reset_mid_message();
    total++; if (both !== 0) $display("FAIL err_overlap got %0d want 0", both); else passed++;
    total++; if (bad_change !== 0) $display("FAIL medida_without_valid got %0d want 0", bad_change); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
